// File: rtl/conv_acc.sv
// conv_acc: per-window accumulator behind the two-term multiply-add unit.
// A MULT_LAT-deep valid/last delay line aligns the issue-side qualifiers with
// the multiplier output. Each window sums the bias and all of its products.
// The window result is saturated to 16 bits and queued in a small output FIFO.
// Issue is credit-gated so that this FIFO can never overflow.
// Optional build macro CONV_ACC_RELU_EN: clamp negative saturated results to 0.
module conv_acc #(
    parameter int MULT_LAT  = 2,
    parameter int ACC_W     = 24,
    parameter int OUT_DEPTH = 4
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_i,
    input  logic               ac_valid_i,
    input  logic               ac_last_i,
    output logic               ac_in_ready_o,
    input  logic signed [15:0] am_mult_i,
    input  logic signed [15:0] ac_bias_i,
    output logic               ac_out_valid_o,
    input  logic               ac_out_ready_i,
    output logic        [15:0] ac_out_data_o,
    output logic               ac_busy_o,
    output logic               ac_ovf_o
);

    localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int PW = $clog2(OUT_DEPTH + MULT_LAT + 1) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                    state_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic                      ovf_reg;
    logic                      in_ready_reg;

    logic [MULT_LAT-1:0]       v_dl_reg;
    logic [MULT_LAT-1:0]       l_dl_reg;
    logic [MULT_LAT-1:0]       v_dl_next;
    logic [MULT_LAT-1:0]       l_dl_next;

    logic [15:0]               mem_reg [OUT_DEPTH];
    logic [AW-1:0]             wr_ptr_reg;
    logic [AW-1:0]             rd_ptr_reg;
    logic [CW-1:0]             count_reg;
    logic [CW-1:0]             count_next;

    logic                      issue;
    logic                      v_d;
    logic                      l_d;
    logic                      push;
    logic                      pop;
    logic                      fifo_valid;
    logic signed [ACC_W-1:0]   mult_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   sum;
    logic                      sat_hi;
    logic                      sat_lo;
    logic [15:0]               sat_val;
    logic [15:0]               push_data;
    logic [PW-1:0]             pend_lat;
    logic [PW-1:0]             pending_next;

    // A term is taken only while a credit is available.
    assign issue = ac_valid_i & in_ready_reg;

    // Next contents of the delay line: stage 0 takes this cycle's issue.
    // Every later stage takes the stage before it.
    generate
        for (genvar gi = 0; gi < MULT_LAT; gi++) begin : g_dl
            if (gi == 0) begin : g_head
                assign v_dl_next[gi] = issue;
                assign l_dl_next[gi] = issue & ac_last_i;
            end else begin : g_tail
                assign v_dl_next[gi] = v_dl_reg[gi-1];
                assign l_dl_next[gi] = l_dl_reg[gi-1];
            end
        end
    endgenerate

    // Shift the valid/last qualifiers toward the multiplier output.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            v_dl_reg <= '0;
            l_dl_reg <= '0;
        end else begin
            v_dl_reg <= v_dl_next;
            l_dl_reg <= l_dl_next;
        end
    end

    assign v_d = v_dl_reg[MULT_LAT-1];
    assign l_d = l_dl_reg[MULT_LAT-1];

    // Add the aligned product to the running sum, then saturate to 16 bits.
    // A window that starts in IDLE begins from the bias.
    always_comb begin
        mult_ext = {{(ACC_W-16){am_mult_i[15]}}, am_mult_i};
        bias_ext = {{(ACC_W-16){ac_bias_i[15]}}, ac_bias_i};
        sum      = ((state_reg == IDLE) ? bias_ext : acc_reg) + mult_ext;
        // The value fits in 16 bits only if bits [ACC_W-1:15] are all copies of the sign.
        sat_hi   = ~sum[ACC_W-1] & (|sum[ACC_W-2:15]);
        sat_lo   =  sum[ACC_W-1] & ~(&sum[ACC_W-2:15]);
        if (sat_hi) begin
            sat_val = 16'h7FFF;
        end else if (sat_lo) begin
            sat_val = 16'h8000;
        end else begin
            sat_val = sum[15:0];
        end
`ifdef CONV_ACC_RELU_EN
        push_data = sat_val[15] ? 16'h0000 : sat_val;
`else
        push_data = sat_val;
`endif
    end

    assign push       = v_d & l_d;
    assign fifo_valid = (count_reg != '0);
    assign pop        = fifo_valid & ac_out_ready_i;

    // Window FSM: accumulate non-last terms and finish the window on the last term.
    // The overflow flag is sticky.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else if (v_d) begin
            if (l_d) begin
                state_reg <= IDLE;
                if (sat_hi | sat_lo) begin
                    ovf_reg <= 1'b1;
                end
            end else begin
                acc_reg   <= sum;
                state_reg <= ACCUM;
            end
        end
    end

    // Result storage: the memory is written only and is not reset.
    // The count decides whether an entry is valid.
    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        count_next = count_reg + CW'(push) - CW'(pop);
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    // Credits: results already queued, plus window ends still in the delay line.
    // The count includes this cycle's issue, so one registered cycle of ready
    // can never overfill the FIFO.
    always_comb begin
        pend_lat = '0;
        for (int i = 0; i < MULT_LAT; i++) begin
            pend_lat = pend_lat + PW'(l_dl_next[i]);
        end
        pending_next = PW'(count_next) + pend_lat;
    end

    // Registered issue permission.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            in_ready_reg <= 1'b1;
        end else begin
            in_ready_reg <= (pending_next < PW'(OUT_DEPTH));
        end
    end

    assign ac_in_ready_o  = in_ready_reg;
    assign ac_out_valid_o = fifo_valid;
    assign ac_out_data_o  = fifo_valid ? mem_reg[rd_ptr_reg] : 16'h0000;
    assign ac_busy_o      = (state_reg == ACCUM) | (|v_dl_reg);
    assign ac_ovf_o       = ovf_reg;

endmodule

// File: tb/tb_conv_acc.sv
// tb_conv_acc: bench for conv_acc.
// It runs directed window scenarios, then randomized windows with a randomly
// stalling consumer. Popped results are compared with a per-window arithmetic
// model (sum, saturate, optional ReLU).
module tb_conv_acc;

    logic        sys_clk_i = 1'b0;
    logic        sys_rst_i;
    logic        ac_valid_i;
    logic        ac_last_i;
    logic        ac_in_ready_o;
    logic [15:0] am_mult_i;
    logic [15:0] ac_bias_i;
    logic        ac_out_valid_o;
    logic        ac_out_ready_i;
    logic [15:0] ac_out_data_o;
    logic        ac_busy_o;
    logic        ac_ovf_o;

    logic [15:0] issue_prod;
    logic [15:0] prod_d1;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_q[$];
    bit exp_sat_q[$];
    int win_acc;
    bit in_win;
    bit rand_rdy;
    bit popped_sat;
    int mon_e;
    bit mon_s;

    always #5 sys_clk_i = ~sys_clk_i;

    conv_acc #(
        .MULT_LAT (2),
        .ACC_W    (24),
        .OUT_DEPTH(4)
    ) dut (
        .sys_clk_i     (sys_clk_i),
        .sys_rst_i     (sys_rst_i),
        .ac_valid_i    (ac_valid_i),
        .ac_last_i     (ac_last_i),
        .ac_in_ready_o (ac_in_ready_o),
        .am_mult_i     (am_mult_i),
        .ac_bias_i     (ac_bias_i),
        .ac_out_valid_o(ac_out_valid_o),
        .ac_out_ready_i(ac_out_ready_i),
        .ac_out_data_o (ac_out_data_o),
        .ac_busy_o     (ac_busy_o),
        .ac_ovf_o      (ac_ovf_o)
    );

    // Multiplier stand-in: the scripted product appears two cycles after issue.
    always @(posedge sys_clk_i) begin
        prod_d1   <= issue_prod;
        am_mult_i <= prod_d1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model one accepted term. A window's result is the bias plus all of its
    // products, saturated to 16 bits.
    task automatic model_term(input bit last, input logic [15:0] prod);
        int r;
        bit s;
        if (!in_win) begin
            win_acc = int'($signed(ac_bias_i));
            in_win  = 1'b1;
        end
        win_acc = win_acc + int'($signed(prod));
        if (last) begin
            s = (win_acc > 32767) || (win_acc < -32768);
            r = (win_acc > 32767) ? 32767 : ((win_acc < -32768) ? -32768 : win_acc);
`ifdef CONV_ACC_RELU_EN
            if (r < 0) r = 0;
`endif
            exp_q.push_back(r & 32'h0000FFFF);
            exp_sat_q.push_back(s);
            in_win = 1'b0;
        end
    endtask

    task automatic step();
        if (rand_rdy) ac_out_ready_i = ($urandom_range(0, 3) != 0);
        if (!ac_valid_i) issue_prod = 16'($urandom);
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic issue_term(input bit last, input logic [15:0] prod);
        int w;
        w = 0;
        while (!ac_in_ready_o && w < 200) begin
            step();
            w++;
        end
        if (w >= 200) chk("issue_ready_timeout", 32'(w), 32'(0));
        ac_valid_i = 1'b1;
        ac_last_i  = last;
        issue_prod = prod;
        if (ac_in_ready_o) model_term(last, prod);
        step();
        ac_valid_i = 1'b0;
        ac_last_i  = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        rand_rdy       = 1'b0;
        ac_out_ready_i = 1'b1;
        while ((exp_q.size() != 0 || ac_busy_o || ac_out_valid_o) && w < 500) begin
            step();
            w++;
        end
        chk("drain_done", 32'(w < 500), 32'(1));
    endtask

    task automatic do_reset();
        sys_rst_i  = 1'b1;
        ac_valid_i = 1'b0;
        ac_last_i  = 1'b0;
        step();
        sys_rst_i  = 1'b0;
        exp_q.delete();
        exp_sat_q.delete();
        in_win     = 1'b0;
        popped_sat = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(ac_in_ready_o), 32'(1));
        chk({tag, "_out_valid"}, 32'(ac_out_valid_o), 32'(0));
        chk({tag, "_out_data"}, 32'(ac_out_data_o), 32'(0));
        chk({tag, "_busy"}, 32'(ac_busy_o), 32'(0));
        chk({tag, "_ovf"}, 32'(ac_ovf_o), 32'(0));
    endtask

    // Output monitor: check each accepted head against the model, and check
    // that the data is zero while the FIFO is empty.
    always @(negedge sys_clk_i) begin
        if (!sys_rst_i) begin
            if (ac_out_valid_o) begin
                if (ac_out_ready_i) begin
                    chk("out_expected_avail", 32'(exp_q.size() != 0), 32'(1));
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        mon_s = exp_sat_q.pop_front();
                        chk("out_data", 32'(ac_out_data_o), 32'(mon_e));
                        if (mon_s) popped_sat = 1'b1;
                        if (popped_sat) chk("ovf_sticky", 32'(ac_ovf_o), 32'(1));
                    end
                end
            end else begin
                chk("empty_data_zero", 32'(ac_out_data_o), 32'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int len;
        sys_rst_i      = 1'b1;
        ac_valid_i     = 1'b0;
        ac_last_i      = 1'b0;
        ac_out_ready_i = 1'b1;
        ac_bias_i      = 16'h0000;
        issue_prod     = 16'h0000;
        rand_rdy       = 1'b0;
        in_win         = 1'b0;
        popped_sat     = 1'b0;
        step();
        do_reset();
        check_reset_state("reset");

        // Three-term window: 10 + 100 - 20 + 5 = 95; valid at t0+5.
        ac_bias_i = 16'd10;
        issue_term(1'b0, 16'd100);
        issue_term(1'b0, 16'hFFEC);
        issue_term(1'b1, 16'd5);
        step();
        chk("w3_valid_t4", 32'(ac_out_valid_o), 32'(0));
        chk("w3_busy_t4", 32'(ac_busy_o), 32'(1));
        step();
        chk("w3_valid_t5", 32'(ac_out_valid_o), 32'(1));
        chk("w3_data", 32'(ac_out_data_o), 32'd95);
        chk("w3_ovf", 32'(ac_ovf_o), 32'(0));
        chk("w3_busy_t5", 32'(ac_busy_o), 32'(0));
        drain();

        // Positive saturation, then ovf stays set through a clean window.
        ac_bias_i = 16'd1;
        issue_term(1'b1, 16'h7FFF);
        idle(2);
        chk("satp_valid", 32'(ac_out_valid_o), 32'(1));
        chk("satp_data", 32'(ac_out_data_o), 32'h7FFF);
        chk("satp_ovf", 32'(ac_ovf_o), 32'(1));
        drain();
        ac_bias_i = 16'd0;
        issue_term(1'b1, 16'd3);
        idle(2);
        chk("sticky_data", 32'(ac_out_data_o), 32'd3);
        chk("sticky_ovf", 32'(ac_ovf_o), 32'(1));
        drain();

        // Negative saturation after a reset that clears ovf.
        do_reset();
        chk("rst2_ovf", 32'(ac_ovf_o), 32'(0));
        ac_bias_i = 16'h8000;
        issue_term(1'b1, 16'hFFFF);
        idle(2);
        chk("satn_data", 32'(ac_out_data_o), 32'h8000);
        chk("satn_ovf", 32'(ac_ovf_o), 32'(1));
        drain();

        // Credit limit: stalled consumer, six single-term windows attempted.
        ac_bias_i      = 16'd0;
        ac_out_ready_i = 1'b0;
        accepted       = 0;
        for (int i = 0; i < 6; i++) begin
            if (ac_in_ready_o) begin
                ac_valid_i = 1'b1;
                ac_last_i  = 1'b1;
                issue_prod = 16'(accepted + 1);
                model_term(1'b1, 16'(accepted + 1));
                accepted++;
            end
            step();
            ac_valid_i = 1'b0;
            ac_last_i  = 1'b0;
        end
        chk("credit_accepted", 32'(accepted), 32'd4);
        chk("credit_ready_low", 32'(ac_in_ready_o), 32'(0));
        idle(3);
        chk("credit_full_valid", 32'(ac_out_valid_o), 32'(1));
        chk("credit_head", 32'(ac_out_data_o), 32'd1);
        chk("credit_still_low", 32'(ac_in_ready_o), 32'(0));
        ac_out_ready_i = 1'b1;
        for (int p = accepted + 1; p <= 6; p++) begin
            issue_term(1'b1, 16'(p));
        end
        drain();

        // Reset in mid-window discards the partial sum.
        ac_bias_i = 16'd0;
        issue_term(1'b0, 16'd50);
        issue_term(1'b0, 16'd50);
        do_reset();
        check_reset_state("midrst");
        issue_term(1'b1, 16'd7);
        idle(2);
        chk("midrst_data", 32'(ac_out_data_o), 32'd7);
        drain();

        // Negative single-term result: ReLU clamps it when enabled.
        ac_bias_i = 16'd0;
        issue_term(1'b1, 16'hFFFB);
        idle(2);
`ifdef CONV_ACC_RELU_EN
        chk("neg_data", 32'(ac_out_data_o), 32'h0000);
`else
        chk("neg_data", 32'(ac_out_data_o), 32'hFFFB);
`endif
        drain();

        // Randomized windows with random gaps and a randomly stalling consumer.
        for (int b = 0; b < 8; b++) begin
            ac_bias_i = 16'($urandom);
            rand_rdy  = 1'b1;
            for (int w = 0; w < 10; w++) begin
                len = $urandom_range(1, 5);
                for (int k = 0; k < len; k++) begin
                    issue_term(k == len - 1, 16'($urandom));
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
            end
            drain();
        end

        chk("final_queue_empty", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
